// File: rtl/jpeg_bs_pkg.sv
// Shared types and constants for the JPEG bitstream unstuffer.
package jpeg_bs_pkg;

  typedef enum logic [1:0] {
    S_DATA   = 2'd0,
    S_FF     = 2'd1,
    S_MARKER = 2'd2
  } state_t;

  localparam logic [7:0] JPEG_FF    = 8'hFF;
  localparam logic [7:0] JPEG_STUFF = 8'h00;
  localparam logic [7:0] JPEG_EOI   = 8'hD9;
  localparam logic [7:0] JPEG_RST0  = 8'hD0;

  localparam int JPEG_BUF_W = 32;
  localparam int JPEG_WIN_W = 16;

endpackage

// File: rtl/jpeg_bitstream_unstuffer_shifter.sv
// Next-state datapath of the bit buffer: drop consumed MSBs, then append a byte
// directly below the remaining valid bits.
module jpeg_bs_shifter #(
  parameter int BUF_W = 32,
  parameter int CNT_W = 6
) (
  input  logic [BUF_W-1:0] buf_q,
  input  logic [CNT_W-1:0] count,
  input  logic [CNT_W-1:0] shift_len,
  input  logic             append_en,
  input  logic [7:0]       append_byte,
  output logic [BUF_W-1:0] buf_next,
  output logic [CNT_W-1:0] count_next
);

  logic [CNT_W-1:0] count_shifted;
  logic [BUF_W-1:0] byte_placed;

  // Bits below count are always zero, so OR-ing the byte in is safe.
  always_comb begin
    count_shifted = count - shift_len;
    byte_placed   = {append_byte, {(BUF_W-8){1'b0}}} >> count_shifted;
    buf_next      = buf_q << shift_len;
    count_next    = count_shifted;
    if (append_en) begin
      buf_next   = buf_next | byte_placed;
      count_next = count_shifted + CNT_W'(8);
    end
  end

endmodule

// File: rtl/jpeg_bitstream_unstuffer.sv
// Receive-side JPEG byte unstuffer: strips 0xFF00 stuffing and 0xFF fill,
// stalls on markers, and exposes an MSB-aligned bit window to the Huffman decoder.
module jpeg_bitstream_unstuffer
  import jpeg_bs_pkg::*;
#(
  parameter int BUF_W = JPEG_BUF_W,
  parameter int WIN_W = JPEG_WIN_W,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic [WIN_W-1:0] win_data,
  output logic [CNT_W-1:0] win_count,
  input  logic             consume_valid,
  input  logic [4:0]       consume_len,
  output logic             marker_valid,
  output logic [7:0]       marker_code,
  input  logic             marker_ack,
  output logic             err_underflow,
  output logic [1:0]       dbg_state
);

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready.
  // in_ready is registered and only asserted when a full byte of room is guaranteed.
  localparam logic [CNT_W-1:0] ROOM_LIMIT = CNT_W'(BUF_W - 8);

  state_t           state, next_state;
  logic [BUF_W-1:0] bit_buf, buf_next;
  logic [CNT_W-1:0] bit_count, count_next;
  logic [CNT_W-1:0] len_ext, shift_len;
  logic             take, consume_req, consume_ok, underflow;
  logic             app_en, marker_load;
  logic [7:0]       app_byte;

  assign take        = in_valid && in_ready && !flush;
  assign len_ext     = CNT_W'(consume_len);
  assign consume_req = consume_valid && !flush && (consume_len != 5'd0);
  assign consume_ok  = consume_req && (len_ext <= bit_count);
  assign underflow   = consume_req && (len_ext > bit_count);
  assign shift_len   = consume_ok ? len_ext : '0;

  always_comb begin
    next_state  = state;
    app_en      = 1'b0;
    app_byte    = in_data;
    marker_load = 1'b0;
    case (state)
      S_DATA: begin
        if (take) begin
          if (in_data == JPEG_FF) next_state = S_FF;
          else                    app_en     = 1'b1;
        end
      end
      S_FF: begin
        if (take) begin
          if (in_data == JPEG_STUFF) begin
            app_en     = 1'b1;
            app_byte   = JPEG_FF;
            next_state = S_DATA;
          end else if (in_data != JPEG_FF) begin
            marker_load = 1'b1;
            next_state  = S_MARKER;
          end
        end
      end
      S_MARKER: if (marker_ack) next_state = S_DATA;
      default:  next_state = S_DATA;
    endcase
  end

  jpeg_bs_shifter #(.BUF_W(BUF_W), .CNT_W(CNT_W)) u_shifter (
    .buf_q       (bit_buf),
    .count       (bit_count),
    .shift_len   (shift_len),
    .append_en   (app_en),
    .append_byte (app_byte),
    .buf_next    (buf_next),
    .count_next  (count_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_buf       <= '0;
      bit_count     <= '0;
      state         <= S_DATA;
      in_ready      <= 1'b0;
      marker_valid  <= 1'b0;
      marker_code   <= 8'h00;
      err_underflow <= 1'b0;
    end else if (flush) begin
      bit_buf       <= '0;
      bit_count     <= '0;
      state         <= S_DATA;
      in_ready      <= 1'b0;
      marker_valid  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      bit_buf   <= buf_next;
      bit_count <= count_next;
      state     <= next_state;
      in_ready  <= (next_state != S_MARKER) && (count_next <= ROOM_LIMIT);
      if (marker_load) begin
        marker_code  <= in_data;
        marker_valid <= 1'b1;
      end else if (state == S_MARKER && marker_ack) begin
        marker_valid <= 1'b0;
      end
      if (underflow) err_underflow <= 1'b1;
    end
  end

  assign win_data  = bit_buf[BUF_W-1 -: WIN_W];
  assign win_count = bit_count;
  assign dbg_state = state;

endmodule

// File: tb/tb_jpeg_bitstream_unstuffer.sv
// Directed bench for jpeg_bitstream_unstuffer: unstuffing, fill, markers,
// consume/append overlap, underflow and mid-stream reset.
module tb_jpeg_bitstream_unstuffer;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [15:0] win_data;
  logic [5:0]  win_count;
  logic        consume_valid;
  logic [4:0]  consume_len;
  logic        marker_valid;
  logic [7:0]  marker_code;
  logic        marker_ack;
  logic        err_underflow;
  logic [1:0]  dbg_state;

  int cmp_cnt;
  int fail_cnt;

  jpeg_bitstream_unstuffer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .win_data      (win_data),
    .win_count     (win_count),
    .consume_valid (consume_valid),
    .consume_len   (consume_len),
    .marker_valid  (marker_valid),
    .marker_code   (marker_code),
    .marker_ack    (marker_ack),
    .err_underflow (err_underflow),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change on the falling edge, outputs are read there too
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    cmp_cnt++;
    if (!in_ready) begin
      fail_cnt++;
      $display("FAIL send_timeout byte=%02h in_ready stayed %0b, required 1", b, in_ready);
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_consume(input logic [4:0] len);
    @(negedge clk);
    consume_valid = 1'b1;
    consume_len   = len;
    @(negedge clk);
    consume_valid = 1'b0;
    consume_len   = 5'd0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    cmp_cnt++; if (win_count !== 6'd0)   begin fail_cnt++; $display("FAIL reset_count got %0d exp 0", win_count); end
    cmp_cnt++; if (win_data !== 16'h0)   begin fail_cnt++; $display("FAIL reset_data got %04h exp 0000", win_data); end
    cmp_cnt++; if (in_ready !== 1'b0)    begin fail_cnt++; $display("FAIL reset_ready got %0b exp 0", in_ready); end
    cmp_cnt++; if (marker_valid !== 1'b0 || err_underflow !== 1'b0 || marker_code !== 8'h00)
      begin fail_cnt++; $display("FAIL reset_flags got mv=%0b err=%0b code=%02h exp 0/0/00", marker_valid, err_underflow, marker_code); end
    rst_n = 1'b1;
    @(negedge clk);
    cmp_cnt++; if (in_ready !== 1'b1)    begin fail_cnt++; $display("FAIL ready_after_reset got %0b exp 1", in_ready); end
  endtask

  task automatic test_plain_bytes();
    send_byte(8'hA5);
    send_byte(8'h3C);
    cmp_cnt++; if (win_count !== 6'd16)   begin fail_cnt++; $display("FAIL plain_count got %0d exp 16", win_count); end
    cmp_cnt++; if (win_data !== 16'hA53C) begin fail_cnt++; $display("FAIL plain_data got %04h exp A53C", win_data); end
    send_byte(8'h01);
    cmp_cnt++; if (in_ready !== 1'b1)     begin fail_cnt++; $display("FAIL ready_at_24 got %0b exp 1", in_ready); end
    send_byte(8'h02);
    cmp_cnt++; if (win_count !== 6'd32)   begin fail_cnt++; $display("FAIL full_count got %0d exp 32", win_count); end
    cmp_cnt++; if (in_ready !== 1'b0)     begin fail_cnt++; $display("FAIL ready_at_32 got %0b exp 0", in_ready); end
    do_flush();
    cmp_cnt++; if (win_count !== 6'd0)    begin fail_cnt++; $display("FAIL flush_count got %0d exp 0", win_count); end
  endtask

  task automatic test_stuffing();
    send_byte(8'hFF);
    cmp_cnt++; if (win_count !== 6'd0)    begin fail_cnt++; $display("FAIL ff_pending_count got %0d exp 0", win_count); end
    send_byte(8'h00);
    send_byte(8'h12);
    cmp_cnt++; if (win_count !== 6'd16)   begin fail_cnt++; $display("FAIL stuff_count got %0d exp 16", win_count); end
    cmp_cnt++; if (win_data !== 16'hFF12) begin fail_cnt++; $display("FAIL stuff_data got %04h exp FF12", win_data); end
    cmp_cnt++; if (marker_valid !== 1'b0) begin fail_cnt++; $display("FAIL stuff_marker got %0b exp 0", marker_valid); end
    do_flush();
  endtask

  task automatic test_marker();
    send_byte(8'h55);
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'hD9);
    cmp_cnt++; if (win_count !== 6'd8)     begin fail_cnt++; $display("FAIL marker_count got %0d exp 8", win_count); end
    cmp_cnt++; if (win_data !== 16'h5500)  begin fail_cnt++; $display("FAIL marker_data got %04h exp 5500", win_data); end
    cmp_cnt++; if (marker_valid !== 1'b1)  begin fail_cnt++; $display("FAIL marker_valid got %0b exp 1", marker_valid); end
    cmp_cnt++; if (marker_code !== 8'hD9)  begin fail_cnt++; $display("FAIL marker_code got %02h exp D9", marker_code); end
    cmp_cnt++; if (in_ready !== 1'b0)      begin fail_cnt++; $display("FAIL marker_ready got %0b exp 0", in_ready); end
    do_consume(5'd8);
    cmp_cnt++; if (win_count !== 6'd0)     begin fail_cnt++; $display("FAIL marker_consume got %0d exp 0", win_count); end
    cmp_cnt++; if (marker_valid !== 1'b1)  begin fail_cnt++; $display("FAIL marker_held got %0b exp 1", marker_valid); end
    @(negedge clk);
    marker_ack = 1'b1;
    @(negedge clk);
    marker_ack = 1'b0;
    cmp_cnt++; if (marker_valid !== 1'b0)  begin fail_cnt++; $display("FAIL marker_ack_clear got %0b exp 0", marker_valid); end
    cmp_cnt++; if (in_ready !== 1'b1)      begin fail_cnt++; $display("FAIL marker_ack_ready got %0b exp 1", in_ready); end
    cmp_cnt++; if (dbg_state !== 2'd0)     begin fail_cnt++; $display("FAIL marker_ack_state got %0d exp 0", dbg_state); end
    do_flush();
  endtask

  task automatic test_consume_append();
    send_byte(8'hF0);
    send_byte(8'hF0);
    @(negedge clk);
    in_valid      = 1'b1;
    in_data       = 8'h77;
    consume_valid = 1'b1;
    consume_len   = 5'd4;
    @(negedge clk);
    in_valid      = 1'b0;
    consume_valid = 1'b0;
    consume_len   = 5'd0;
    cmp_cnt++; if (win_count !== 6'd20)   begin fail_cnt++; $display("FAIL overlap_count got %0d exp 20", win_count); end
    cmp_cnt++; if (win_data !== 16'h0F07) begin fail_cnt++; $display("FAIL overlap_data got %04h exp 0F07", win_data); end
    do_consume(5'd16);
    cmp_cnt++; if (win_count !== 6'd4)    begin fail_cnt++; $display("FAIL consume16_count got %0d exp 4", win_count); end
    cmp_cnt++; if (win_data !== 16'h7000) begin fail_cnt++; $display("FAIL consume16_data got %04h exp 7000", win_data); end
    do_flush();
  endtask

  task automatic test_underflow();
    send_byte(8'hAB);
    do_consume(5'd12);
    cmp_cnt++; if (win_count !== 6'd8)     begin fail_cnt++; $display("FAIL under_count got %0d exp 8", win_count); end
    cmp_cnt++; if (win_data !== 16'hAB00)  begin fail_cnt++; $display("FAIL under_data got %04h exp AB00", win_data); end
    cmp_cnt++; if (err_underflow !== 1'b1) begin fail_cnt++; $display("FAIL under_err got %0b exp 1", err_underflow); end
    repeat (3) @(negedge clk);
    cmp_cnt++; if (err_underflow !== 1'b1) begin fail_cnt++; $display("FAIL under_sticky got %0b exp 1", err_underflow); end
    do_flush();
    cmp_cnt++; if (win_count !== 6'd0)     begin fail_cnt++; $display("FAIL under_flush_count got %0d exp 0", win_count); end
    cmp_cnt++; if (err_underflow !== 1'b0) begin fail_cnt++; $display("FAIL under_flush_err got %0b exp 0", err_underflow); end
  endtask

  task automatic test_reset_mid_ff();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'hFF);
    cmp_cnt++; if (win_count !== 6'd24)   begin fail_cnt++; $display("FAIL pre_rst_count got %0d exp 24", win_count); end
    cmp_cnt++; if (dbg_state !== 2'd1)    begin fail_cnt++; $display("FAIL pre_rst_state got %0d exp 1", dbg_state); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    cmp_cnt++; if (win_count !== 6'd0 || win_data !== 16'h0 || in_ready !== 1'b0)
      begin fail_cnt++; $display("FAIL midrst_outputs got cnt=%0d data=%04h rdy=%0b exp 0/0000/0", win_count, win_data, in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h00);
    cmp_cnt++; if (win_count !== 6'd8)    begin fail_cnt++; $display("FAIL post_rst_count got %0d exp 8", win_count); end
    cmp_cnt++; if (win_data !== 16'h0000) begin fail_cnt++; $display("FAIL post_rst_data got %04h exp 0000", win_data); end
    cmp_cnt++; if (dbg_state !== 2'd0)    begin fail_cnt++; $display("FAIL post_rst_state got %0d exp 0", dbg_state); end
  endtask

  initial begin
    cmp_cnt       = 0;
    fail_cnt      = 0;
    rst_n         = 1'b0;
    flush         = 1'b0;
    in_valid      = 1'b0;
    in_data       = 8'h00;
    consume_valid = 1'b0;
    consume_len   = 5'd0;
    marker_ack    = 1'b0;
    test_reset();
    test_plain_bytes();
    test_stuffing();
    test_marker();
    test_consume_append();
    test_underflow();
    test_reset_mid_ff();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
